// File: rtl/ycbcr_to_rgb.sv
// BT.601 full-range YCbCr to RGB converter: three-stage pipeline with valid/ready flow control.
// Define YCBCR2RGB_CLAMP_EN to saturate each channel; otherwise the low WIDTH bits of the sum are kept.
module ycbcr_to_rgb #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] y_in,
  input  logic [WIDTH-1:0] cb_in,
  input  logic [WIDTH-1:0] cr_in,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r_out,
  output logic [WIDTH-1:0] g_out,
  output logic [WIDTH-1:0] b_out,
  output logic             out_last
);

  localparam int PW = 20;
  localparam logic [WIDTH:0] OFFSET = {2'b01, {(WIDTH-1){1'b0}}};
  localparam logic signed [PW-1:0] MAXV = PW'((2**WIDTH) - 1);

  // Fit a signed channel sum into WIDTH bits (saturate or wrap).
  function automatic logic [WIDTH-1:0] fit(input logic signed [PW-1:0] v);
    logic [WIDTH-1:0] res;
`ifdef YCBCR2RGB_CLAMP_EN
    if (v < 20'sd0) begin
      res = {WIDTH{1'b0}};
    end else if (v > MAXV) begin
      res = {WIDTH{1'b1}};
    end else begin
      res = v[WIDTH-1:0];
    end
`else
    res = v[WIDTH-1:0];
`endif
    return res;
  endfunction

  logic                    r_v1, r_v2, r_v3;
  logic [WIDTH-1:0]        r_y1, r_y2;
  logic signed [WIDTH:0]   r_cbd1, r_crd1;
  logic                    r_last1, r_last2, r_last3;
  logic signed [PW-1:0]    r_pr, r_pgb, r_pgr, r_pb;
  logic [WIDTH-1:0]        r_r3, r_g3, r_b3;

  logic                    w_adv;
  logic signed [PW-1:0]    w_cbd_x, w_crd_x;
  logic signed [PW-1:0]    w_y_x;
  logic signed [PW-1:0]    w_r_sum, w_g_sum, w_b_sum;

  // Whole pipeline advances whenever the output slot is empty or being drained.
  assign w_adv    = !r_v3 || out_ready;
  assign in_ready = w_adv;

  assign out_valid = r_v3;
  assign r_out     = r_r3;
  assign g_out     = r_g3;
  assign b_out     = r_b3;
  assign out_last  = r_last3;

  assign w_cbd_x = {{(PW-WIDTH-1){r_cbd1[WIDTH]}}, r_cbd1};
  assign w_crd_x = {{(PW-WIDTH-1){r_crd1[WIDTH]}}, r_crd1};
  assign w_y_x   = {{(PW-WIDTH){1'b0}}, r_y2};

  assign w_r_sum = w_y_x + (r_pr >>> 5'd8);
  assign w_g_sum = w_y_x + ((r_pgb + r_pgr) >>> 5'd8);
  assign w_b_sum = w_y_x + (r_pb >>> 5'd8);

  // Stage 1: capture luma and re-centre chroma around zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1    <= 1'b0;
      r_y1    <= {WIDTH{1'b0}};
      r_cbd1  <= {(WIDTH+1){1'b0}};
      r_crd1  <= {(WIDTH+1){1'b0}};
      r_last1 <= 1'b0;
    end else if (w_adv) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_y1    <= y_in;
        r_cbd1  <= {1'b0, cb_in} - OFFSET;
        r_crd1  <= {1'b0, cr_in} - OFFSET;
        r_last1 <= in_last;
      end
    end
  end

  // Stage 2: coefficient products; the green path carries the single rounding term.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v2    <= 1'b0;
      r_y2    <= {WIDTH{1'b0}};
      r_pr    <= {PW{1'b0}};
      r_pgb   <= {PW{1'b0}};
      r_pgr   <= {PW{1'b0}};
      r_pb    <= {PW{1'b0}};
      r_last2 <= 1'b0;
    end else if (w_adv) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_y2    <= r_y1;
        r_pr    <= (20'sd359 * w_crd_x) + 20'sd128;
        r_pgb   <= (-20'sd88 * w_cbd_x) + 20'sd128;
        r_pgr   <= -20'sd183 * w_crd_x;
        r_pb    <= (20'sd454 * w_cbd_x) + 20'sd128;
        r_last2 <= r_last1;
      end
    end
  end

  // Stage 3: scale back, add luma, fit to channel width and hold for the consumer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v3    <= 1'b0;
      r_r3    <= {WIDTH{1'b0}};
      r_g3    <= {WIDTH{1'b0}};
      r_b3    <= {WIDTH{1'b0}};
      r_last3 <= 1'b0;
    end else if (w_adv) begin
      r_v3 <= r_v2;
      if (r_v2) begin
        r_r3    <= fit(w_r_sum);
        r_g3    <= fit(w_g_sum);
        r_b3    <= fit(w_b_sum);
        r_last3 <= r_last2;
      end
    end
  end

endmodule
